// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_MULT = 2'd1,
        RUN_DIV  = 2'd2,
        FIX      = 2'd3
    } mdu_state_e;

    // Iteration counter must be able to hold the full iteration count.
    function automatic int mdu_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mdu_magnitude.sv
// Combinational two's-complement conditional negate; with negate_i = sign bit it yields |value_i|.
module mdu_magnitude #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         negate_i,
    output logic [W-1:0] result_o
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        if (negate_i) begin
            result_o = (~value_i) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result_o = value_i;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) engine feeding HI/LO.
// Optional build macro MDU_DIVZERO_EN: short-circuit divide-by-zero with a div_zero pulse.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = mdu_cnt_width(WIDTH);

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    // Shared accumulator: mult {partial hi, multiplier}, div {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   b_q;
    logic               is_div_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    mdu_magnitude #(.W(WIDTH)) u_abs_a (
        .value_i  (op_a),
        .negate_i (op_a[WIDTH-1]),
        .result_o (mag_a_s)
    );

    mdu_magnitude #(.W(WIDTH)) u_abs_b (
        .value_i  (op_b),
        .negate_i (op_b[WIDTH-1]),
        .result_o (mag_b_s)
    );

    mdu_magnitude #(.W(2*WIDTH)) u_fix_prod (
        .value_i  (prod_q),
        .negate_i (neg_q),
        .result_o (prod_fix_s)
    );

    mdu_magnitude #(.W(WIDTH)) u_fix_quot (
        .value_i  (prod_q[WIDTH-1:0]),
        .negate_i (neg_q),
        .result_o (quot_fix_s)
    );

    mdu_magnitude #(.W(WIDTH)) u_fix_rem (
        .value_i  (prod_q[2*WIDTH-1:WIDTH]),
        .negate_i (neg_rem_q),
        .result_o (rem_fix_s)
    );

    assign mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                       + (prod_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, b_q};

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        step_s = prod_q;
        if (state_q == RUN_DIV) begin
            if (!div_diff_s[WIDTH]) begin
                step_s = {div_diff_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {div_shift_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, prod_q[WIDTH-1:1]};
        end
    end

`ifdef MDU_DIVZERO_EN
    logic div_zero_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // Control FSM, iteration counter, datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            b_q       <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_mult || start_div) begin
                        prod_q    <= {{WIDTH{1'b0}}, mag_a_s};
                        b_q       <= mag_b_s;
                        is_div_q  <= !start_mult;
                        neg_q     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_rem_q <= op_a[WIDTH-1];
                        cnt_q     <= {CNT_W{1'b0}};
`ifdef MDU_DIVZERO_EN
                        if (!start_mult && (op_b == {WIDTH{1'b0}})) begin
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q <= start_mult ? RUN_MULT : RUN_DIV;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= start_mult ? RUN_MULT : RUN_DIV;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                RUN_MULT, RUN_DIV: begin
                    prod_q <= step_s;
                    cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix_s;
                        lo_q <= quot_fix_s;
                    end else begin
                        hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_s[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; honours MDU_DIVZERO_EN for the divide-by-zero case.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_cmp;
    int n_err;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse the selected start(s) from the current cycle (cycle 0) and follow the op until done.
    // Checks busy profile and that hi/lo hold while busy; optionally pokes starts mid-run.
    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic poke, output int done_cyc);
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        logic        busy_bad;
        logic        hold_bad;
        hi_prev    = hi_out;
        lo_prev    = lo_out;
        busy_bad   = 1'b0;
        hold_bad   = 1'b0;
        done_cyc   = -1;
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (hi_out !== hi_prev || lo_out !== lo_prev) hold_bad = 1'b1;
            if (poke && cyc == 5) begin
                start_mult = 1'b1;
                start_div  = 1'b1;
                op_a       = 32'h0000_1234;
                op_b       = 32'h0000_0000;
            end
            @(posedge clock);
            #1;
            start_mult = 1'b0;
            start_div  = 1'b0;
        end
        check({tag, "_busy_run"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
        if (done_cyc > 0) begin
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    int dc;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_op("m7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, dc);
        check("m7x-3_cyc", 32'(dc), 32'd34);
        check("m7x-3_hi", hi_out, 32'hFFFF_FFFF);
        check("m7x-3_lo", lo_out, 32'hFFFF_FFEB);

        // Chained start in the done cycle must be accepted.
        run_op("mmin2", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, dc);
        check("mmin2_cyc", 32'(dc), 32'd34);
        check("mmin2_hi", hi_out, 32'h4000_0000);
        check("mmin2_lo", lo_out, 32'h0000_0000);

        run_op("d100_7", 1'b0, 1'b1, 32'd100, 32'd7, 1'b0, dc);
        check("d100_7_cyc", 32'(dc), 32'd34);
        check("d100_7_lo", lo_out, 32'd14);
        check("d100_7_hi", hi_out, 32'd2);
        check("d100_7_dz", {31'd0, div_zero}, 32'd0);
        @(posedge clock);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);

        run_op("dm7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, dc);
        check("dm7_2_cyc", 32'(dc), 32'd34);
        check("dm7_2_lo", lo_out, 32'hFFFF_FFFD);
        check("dm7_2_hi", hi_out, 32'hFFFF_FFFF);

        run_op("dovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dc);
        check("dovf_lo", lo_out, 32'h8000_0000);
        check("dovf_hi", hi_out, 32'h0000_0000);

        // Both starts high: multiply wins; starts while busy are ignored.
        run_op("both", 1'b1, 1'b1, 32'd6, 32'hFFFF_FFFB, 1'b1, dc);
        check("both_cyc", 32'(dc), 32'd34);
        check("both_hi", hi_out, 32'hFFFF_FFFF);
        check("both_lo", lo_out, 32'hFFFF_FFE2);

        run_op("d7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, dc);
        check("d7_m2_lo", lo_out, 32'hFFFF_FFFD);
        check("d7_m2_hi", hi_out, 32'd1);

        run_op("d5_0", 1'b0, 1'b1, 32'd5, 32'd0, 1'b0, dc);
`ifdef MDU_DIVZERO_EN
        check("d5_0_cyc", 32'(dc), 32'd1);
        check("d5_0_dz", {31'd0, div_zero}, 32'd1);
        check("d5_0_lo", lo_out, 32'hFFFF_FFFD);
        check("d5_0_hi", hi_out, 32'd1);
`else
        check("d5_0_cyc", 32'(dc), 32'd34);
        check("d5_0_dz", {31'd0, div_zero}, 32'd0);
        check("d5_0_lo", lo_out, 32'hFFFF_FFFF);
        check("d5_0_hi", hi_out, 32'd5);
`endif

        // Reset in the middle of a multiply.
        @(negedge clock);
        start_mult = 1'b1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_hi", hi_out, 32'd0);
        check("mid_rst_lo", lo_out, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock);
                #1;
                if (done) saw_done = 1'b1;
            end
            check("mid_no_done", {31'd0, saw_done}, 32'd0);
        end

        run_op("m3x4", 1'b1, 1'b0, 32'd3, 32'd4, 1'b0, dc);
        check("m3x4_cyc", 32'(dc), 32'd34);
        check("m3x4_lo", lo_out, 32'd12);
        check("m3x4_hi", hi_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
